// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage: type codes and
// field widths used by the extractor and the output buffer.
package imm_gen_stage_pkg;

  localparam int TYPE_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [TYPE_W-1:0] {
    IMM_NONE  = 4'd0,
    IMM_I     = 4'd1,
    IMM_S     = 4'd2,
    IMM_B     = 4'd3,
    IMM_U     = 4'd4,
    IMM_J     = 4'd5,
    IMM_Z     = 4'd6,
    IMM_SHAMT = 4'd7,
    IMM_CI    = 4'd8,
    IMM_CLUI  = 4'd9,
    IMM_CIW   = 4'd10,
    IMM_CLW   = 4'd11,
    IMM_CLD   = 4'd12,
    IMM_CB    = 4'd13,
    IMM_CJ    = 4'd14
  } imm_type_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate decoder: assembles the raw field for each type
// and extends it to XLEN, forcing zero on illegal type/width combinations.
module imm_extract
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit RVC_EN = 1'b1
) (
  input  logic [31:0]       inst,
  input  logic [TYPE_W-1:0] imm_type,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic [31:0]     sx;
  logic [31:0]     zx;
  logic            use_sext;
  logic            rvc_type;
  logic [XLEN-1:0] sx_ext;
  logic [XLEN-1:0] zx_ext;
  logic            unused_bits;

  assign unused_bits = ^inst[1:0];

  always_comb begin
    sx       = '0;
    zx       = '0;
    use_sext = 1'b0;
    rvc_type = 1'b0;
    illegal  = 1'b0;
    case (imm_type_e'(imm_type))
      IMM_NONE: ;
      IMM_I: begin
        use_sext = 1'b1;
        sx       = {{20{inst[31]}}, inst[31:20]};
      end
      IMM_S: begin
        use_sext = 1'b1;
        sx       = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      IMM_B: begin
        use_sext = 1'b1;
        sx       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      IMM_U: begin
        use_sext = 1'b1;
        sx       = {inst[31:12], 12'b0};
      end
      IMM_J: begin
        use_sext = 1'b1;
        sx       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      IMM_Z: zx = {27'b0, inst[19:15]};
      IMM_SHAMT: begin
        // RV32 shifts only have a 5-bit amount, so a set bit 25 is malformed
        if (XLEN == 64) begin
          zx = {26'b0, inst[25:20]};
        end else begin
          zx      = {27'b0, inst[24:20]};
          illegal = inst[25];
        end
      end
      IMM_CI: begin
        rvc_type = 1'b1;
        use_sext = 1'b1;
        sx       = {{26{inst[12]}}, inst[12], inst[6:2]};
      end
      IMM_CLUI: begin
        rvc_type = 1'b1;
        use_sext = 1'b1;
        sx       = {{14{inst[12]}}, inst[12], inst[6:2], 12'b0};
      end
      IMM_CIW: begin
        rvc_type = 1'b1;
        zx       = {22'b0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b0};
      end
      IMM_CLW: begin
        rvc_type = 1'b1;
        zx       = {25'b0, inst[5], inst[12:10], inst[6], 2'b0};
      end
      IMM_CLD: begin
        rvc_type = 1'b1;
        zx       = {24'b0, inst[6:5], inst[12:10], 3'b0};
      end
      IMM_CB: begin
        rvc_type = 1'b1;
        use_sext = 1'b1;
        sx       = {{23{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
      end
      IMM_CJ: begin
        rvc_type = 1'b1;
        use_sext = 1'b1;
        sx       = {{20{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                    inst[2], inst[11], inst[5:3], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
    if (rvc_type && !RVC_EN) illegal = 1'b1;
  end

  always_comb begin
    sx_ext       = {XLEN{sx[31]}};
    sx_ext[31:0] = sx;
    zx_ext       = '0;
    zx_ext[31:0] = zx;
    if (illegal)       imm = '0;
    else if (use_sext) imm = sx_ext;
    else               imm = zx_ext;
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the immediate on entry and
// queues {imm, tag, illegal} in a 2-entry FIFO toward decode/issue.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit RVC_EN = 1'b1,
  parameter int TAG_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       inst_i,
  input  logic [TYPE_W-1:0] type_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              illegal_o
);

  logic [XLEN-1:0]  dec_imm;
  logic             dec_illegal;
  logic [XLEN-1:0]  mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic [1:0]       mem_ill;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  imm_extract #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_extract (
    .inst     (inst_i),
    .imm_type (type_i),
    .imm      (dec_imm),
    .illegal  (dec_illegal)
  );

  // Handshake depends only on the registered count, never on ready_i
  assign ready_o   = (count != CNT_W'(2));
  assign valid_o   = (count != '0);
  assign push      = valid_i & ready_o;
  assign pop       = valid_o & ready_i;
  assign imm_o     = mem_imm[rd_ptr];
  assign tag_o     = mem_tag[rd_ptr];
  assign illegal_o = mem_ill[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      mem_ill <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_tag[wr_ptr] <= tag_i;
        mem_ill[wr_ptr] <= dec_illegal;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: three configurations (RV64+RVC, RV32+RVC,
// RV64 without RVC) share one input stream; expectations are hand-computed.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [31:0] inst_i;
  logic [3:0]  type_i;
  logic [63:0] tag_i;

  logic        ready_a, valid_a, ill_a;
  logic [63:0] imm_a, tag_a;
  logic        ready_b, valid_b, ill_b;
  logic [31:0] imm_b;
  logic [63:0] tag_b;
  logic        ready_c, valid_c, ill_c;
  logic [63:0] imm_c, tag_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(64), .RVC_EN(1'b1), .TAG_W(64)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_a),
    .inst_i(inst_i), .type_i(type_i), .tag_i(tag_i), .valid_o(valid_a), .ready_i(ready_i),
    .imm_o(imm_a), .tag_o(tag_a), .illegal_o(ill_a)
  );

  imm_gen_stage #(.XLEN(32), .RVC_EN(1'b1), .TAG_W(64)) u_dut32 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_b),
    .inst_i(inst_i), .type_i(type_i), .tag_i(tag_i), .valid_o(valid_b), .ready_i(ready_i),
    .imm_o(imm_b), .tag_o(tag_b), .illegal_o(ill_b)
  );

  imm_gen_stage #(.XLEN(64), .RVC_EN(1'b0), .TAG_W(64)) u_dut_norvc (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_c),
    .inst_i(inst_i), .type_i(type_i), .tag_i(tag_i), .valid_o(valid_c), .ready_i(ready_i),
    .imm_o(imm_c), .tag_o(tag_c), .illegal_o(ill_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [3:0] t, input logic [63:0] tag);
    inst_i  = inst;
    type_i  = t;
    tag_i   = tag;
    valid_i = 1'b1;
  endtask

  task automatic apply(input logic [31:0] inst, input logic [3:0] t, input logic [63:0] tag);
    drive(inst, t, tag);
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    inst_i = '0; type_i = '0; tag_i = '0;
    #1;
    check("rst_valid", {63'b0, valid_a}, 64'd0);
    check("rst_ready", {63'b0, ready_a}, 64'd1);
    check("rst_imm", imm_a, 64'd0);
    check("rst_tag", tag_a, 64'd0);
    check("rst_ill", {63'b0, ill_a}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Format vectors, ready_i high: each beat visible one edge after acceptance
    apply(32'hFFF0_0093, 4'd1, 64'h11);
    check("i_valid", {63'b0, valid_a}, 64'd1);
    check("i_imm64", imm_a, 64'hFFFF_FFFF_FFFF_FFFF);
    check("i_ill", {63'b0, ill_a}, 64'd0);
    check("i_tag", tag_a, 64'h11);
    check("i_imm32", {32'b0, imm_b}, 64'hFFFF_FFFF);

    apply(32'hFE00_0FE3, 4'd3, 64'h12);
    check("b_imm", imm_a, 64'hFFFF_FFFF_FFFF_FFFE);

    apply(32'h8000_0037, 4'd4, 64'h13);
    check("u_imm64", imm_a, 64'hFFFF_FFFF_8000_0000);
    check("u_imm32", {32'b0, imm_b}, 64'h8000_0000);

    apply(32'h8000_0F80, 4'd2, 64'h14);
    check("s_imm", imm_a, 64'hFFFF_FFFF_FFFF_F81F);

    apply(32'h7FFF_F06F, 4'd5, 64'h15);
    check("j_imm", imm_a, 64'h0000_0000_000F_FFFE);

    apply(32'h000F_8000, 4'd6, 64'h16);
    check("z_imm", imm_a, 64'd31);

    apply(32'h03F0_0000, 4'd7, 64'h17);
    check("shamt64_imm", imm_a, 64'd63);
    check("shamt64_ill", {63'b0, ill_a}, 64'd0);
    check("shamt32_ill", {63'b0, ill_b}, 64'd1);
    check("shamt32_imm", {32'b0, imm_b}, 64'd0);
    check("shamt32_valid", {63'b0, valid_b}, 64'd1);

    apply(32'h01F0_0000, 4'd7, 64'h18);
    check("shamt32_ok_imm", {32'b0, imm_b}, 64'd31);
    check("shamt32_ok_ill", {63'b0, ill_b}, 64'd0);

    apply(32'h0000_BFFD, 4'd14, 64'h19);
    check("cj_imm", imm_a, 64'hFFFF_FFFF_FFFF_FFFE);
    check("cj_ill", {63'b0, ill_a}, 64'd0);
    check("cj_imm32", {32'b0, imm_b}, 64'hFFFF_FFFE);
    check("cj_norvc_imm", imm_c, 64'd0);
    check("cj_norvc_ill", {63'b0, ill_c}, 64'd1);
    check("cj_norvc_tag", tag_c, 64'h19);

    apply(32'h0000_1004, 4'd8, 64'h1A);
    check("ci_imm", imm_a, 64'hFFFF_FFFF_FFFF_FFE1);
    apply(32'h0000_0004, 4'd9, 64'h1B);
    check("clui_imm", imm_a, 64'h1000);
    apply(32'h0000_0780, 4'd10, 64'h1C);
    check("ciw_imm", imm_a, 64'd960);
    apply(32'h0000_1C60, 4'd11, 64'h1D);
    check("clw_imm", imm_a, 64'd124);
    apply(32'h0000_1C60, 4'd12, 64'h1E);
    check("cld_imm", imm_a, 64'd248);
    apply(32'h0000_1000, 4'd13, 64'h1F);
    check("cb_imm", imm_a, 64'hFFFF_FFFF_FFFF_FF00);

    apply(32'hFFFF_FFFF, 4'd15, 64'h20);
    check("rsv_imm", imm_a, 64'd0);
    check("rsv_ill", {63'b0, ill_a}, 64'd1);
    apply(32'hFFFF_FFFF, 4'd0, 64'h21);
    check("none_imm", imm_a, 64'd0);
    check("none_ill", {63'b0, ill_a}, 64'd0);

    // Back-to-back at count 1: simultaneous push/pop keeps the stream moving
    tick();
    check("drain_valid", {63'b0, valid_a}, 64'd0);
    drive(32'hFFF0_0093, 4'd1, 64'h31);
    tick();
    drive(32'h0010_0093, 4'd1, 64'h32);
    tick();
    valid_i = 1'b0;
    check("b2b_tag", tag_a, 64'h32);
    check("b2b_imm", imm_a, 64'd1);
    check("b2b_valid", {63'b0, valid_a}, 64'd1);
    tick();

    // Backpressure: third beat must wait, order preserved
    ready_i = 1'b0;
    apply(32'h0020_0093, 4'd1, 64'h41);
    check("bp_ready1", {63'b0, ready_a}, 64'd1);
    apply(32'h0030_0093, 4'd1, 64'h42);
    check("bp_ready2", {63'b0, ready_a}, 64'd0);
    apply(32'h0040_0093, 4'd1, 64'h43);
    check("bp_hold_tag", tag_a, 64'h41);
    check("bp_hold_imm", imm_a, 64'd2);
    ready_i = 1'b1;
    tick();
    check("bp_second_tag", tag_a, 64'h42);
    check("bp_second_imm", imm_a, 64'd3);
    tick();
    check("bp_no_third", {63'b0, valid_a}, 64'd0);

    // Flush with a full buffer and an offered beat
    ready_i = 1'b0;
    apply(32'h0050_0093, 4'd1, 64'h51);
    apply(32'h0060_0093, 4'd1, 64'h52);
    drive(32'h0070_0093, 4'd1, 64'h53);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_valid", {63'b0, valid_a}, 64'd0);
    check("flush_ready", {63'b0, ready_a}, 64'd1);

    // Flush with room available: the offered beat must still be dropped
    apply(32'h0080_0093, 4'd1, 64'h61);
    drive(32'h0090_0093, 4'd1, 64'h62);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush1_valid", {63'b0, valid_a}, 64'd0);
    ready_i = 1'b1;
    tick();
    check("flush1_absent", {63'b0, valid_a}, 64'd0);

    // Post-flush pointers still deliver the next beat correctly
    apply(32'h00A0_0093, 4'd1, 64'h71);
    check("postflush_tag", tag_a, 64'h71);
    check("postflush_imm", imm_a, 64'd10);

    // Asynchronous reset mid-cycle
    ready_i = 1'b0;
    apply(32'hFFF0_0093, 4'd15, 64'hAA);
    check("pre_rst_valid", {63'b0, valid_a}, 64'd1);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", {63'b0, valid_a}, 64'd0);
    check("arst_imm", imm_a, 64'd0);
    check("arst_tag", tag_a, 64'd0);
    check("arst_ill", {63'b0, ill_a}, 64'd0);
    check("arst_ready", {63'b0, ready_a}, 64'd1);
    #1 rst_i = 1'b0;
    tick();
    check("post_rst_valid", {63'b0, valid_a}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
